// File: rtl/hsi_core_cfg_sequencer.sv
// Drives one vector-core job over OBI: program op/bands, kick START, poll STATUS.
// Reports done with core error, bus error or poll timeout.
module hsi_core_cfg_sequencer #(
  parameter int          OP_CODE_WIDTH   = 8,
  parameter int          NUM_BANDS_WIDTH = 8,
  parameter int          ERR_WIDTH       = 8,
  parameter logic [31:0] BASE_ADDR       = 32'h0,
  parameter int          POLL_MAX        = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [OP_CODE_WIDTH-1:0]   cmd_op_code_i,
  input  logic [NUM_BANDS_WIDTH-1:0] cmd_num_bands_i,
  output logic                       done_o,
  output logic [ERR_WIDTH-1:0]       core_err_code_o,
  output logic                       bus_err_o,
  output logic                       timeout_o,
  output logic                       req_o,
  output logic                       we_o,
  output logic [3:0]                 be_o,
  output logic [31:0]                addr_o,
  output logic [31:0]                wdata_o,
  input  logic                       gnt_i,
  input  logic                       rvalid_i,
  input  logic [31:0]                rdata_i,
  input  logic                       err_i
);

  localparam int PCW = $clog2(POLL_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_REPORT} state_t;
  // Encoding doubles as the word offset of the target register.
  typedef enum logic [1:0] {WR_OP, WR_NB, WR_START, RD_STAT} step_t;

  state_t                     r_state;
  step_t                      r_step;
  logic [NUM_BANDS_WIDTH-1:0] r_nb;
  logic [PCW-1:0]             r_poll;
  logic                       r_req;
  logic                       r_we;
  logic [3:0]                 r_be;
  logic [31:0]                r_addr;
  logic [31:0]                r_wdata;
  logic                       r_done;
  logic [ERR_WIDTH-1:0]       r_err_code;
  logic                       r_bus_err;
  logic                       r_timeout;

  logic [PCW-1:0]             w_poll_nxt;
  logic                       w_unused_rdata;

  assign w_poll_nxt     = r_poll + 1'b1;
  assign w_unused_rdata = ^rdata_i;

  function automatic logic [31:0] step_addr(input step_t s);
    return BASE_ADDR + {28'd0, s, 2'b00};
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_step     <= WR_OP;
      r_nb       <= '0;
      r_poll     <= '0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_be       <= 4'h0;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_done     <= 1'b0;
      r_err_code <= '0;
      r_bus_err  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            r_nb       <= cmd_num_bands_i;
            r_err_code <= '0;
            r_bus_err  <= 1'b0;
            r_timeout  <= 1'b0;
            r_poll     <= '0;
            r_step     <= WR_OP;
            r_req      <= 1'b1;
            r_we       <= 1'b1;
            r_be       <= 4'hF;
            r_addr     <= step_addr(WR_OP);
            r_wdata    <= 32'(cmd_op_code_i);
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (gnt_i) begin
            r_req   <= 1'b0;
            r_be    <= 4'h0;
            r_state <= S_RSP;
          end
        end
        S_RSP: begin
          if (rvalid_i) begin
            if (err_i) begin
              r_bus_err <= 1'b1;
              r_done    <= 1'b1;
              r_state   <= S_REPORT;
            end else begin
              // Default: issue the next (or repeated) transaction.
              r_req   <= 1'b1;
              r_be    <= 4'hF;
              r_state <= S_REQ;
              case (r_step)
                WR_OP: begin
                  r_step  <= WR_NB;
                  r_addr  <= step_addr(WR_NB);
                  r_wdata <= 32'(r_nb);
                end
                WR_NB: begin
                  r_step  <= WR_START;
                  r_addr  <= step_addr(WR_START);
                  r_wdata <= 32'h1;
                end
                WR_START: begin
                  r_step  <= RD_STAT;
                  r_we    <= 1'b0;
                  r_addr  <= step_addr(RD_STAT);
                  r_wdata <= 32'h0;
                end
                default: begin
                  r_poll <= w_poll_nxt;
                  if (rdata_i[0] || (w_poll_nxt == PCW'(POLL_MAX))) begin
                    if (rdata_i[0]) r_err_code <= rdata_i[ERR_WIDTH:1];
                    else            r_timeout  <= 1'b1;
                    r_req   <= 1'b0;
                    r_be    <= 4'h0;
                    r_done  <= 1'b1;
                    r_state <= S_REPORT;
                  end
                end
              endcase
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready_o     = (r_state == S_IDLE);
  assign done_o          = r_done;
  assign core_err_code_o = r_err_code;
  assign bus_err_o       = r_bus_err;
  assign timeout_o       = r_timeout;
  assign req_o           = r_req;
  assign we_o            = r_we;
  assign be_o            = r_be;
  assign addr_o          = r_addr;
  assign wdata_o         = r_wdata;

endmodule

// File: tb/tb_hsi_core_cfg_sequencer.sv
// Directed bench: behavioural OBI responder with programmable grant delay,
// STATUS sequence and error injection; immediate assertions at each check.
module tb_hsi_core_cfg_sequencer;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_op;
  logic [7:0]  cmd_nb;
  logic        done_o;
  logic [7:0]  core_err;
  logic        bus_err;
  logic        timeout;
  logic        req_o, we_o;
  logic [3:0]  be_o;
  logic [31:0] addr_o, wdata_o;
  logic        gnt_i, rvalid_i, err_i;
  logic [31:0] rdata_i;

  always #5 clk = ~clk;

  hsi_core_cfg_sequencer #(
    .OP_CODE_WIDTH(8), .NUM_BANDS_WIDTH(8), .ERR_WIDTH(8),
    .BASE_ADDR(BASE), .POLL_MAX(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_code_i(cmd_op), .cmd_num_bands_i(cmd_nb),
    .done_o(done_o), .core_err_code_o(core_err),
    .bus_err_o(bus_err), .timeout_o(timeout),
    .req_o(req_o), .we_o(we_o), .be_o(be_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i), .err_i(err_i)
  );

  int checks = 0;
  int errors = 0;

  // Responder configuration and transaction log
  int          gnt_delay = 0;
  int          err_at    = -1;
  int          stat_q[$];
  int          stat_idx  = 0;
  logic [31:0] log_addr[$];
  logic [31:0] log_wd[$];
  logic        log_we[$];
  int          n_rd = 0;
  int          stab_err = 0;
  int          max_wait = 0;
  int          done_cnt = 0;
  logic        force_rv = 1'b0;
  logic        force_err = 1'b0;

  task automatic clear_log();
    log_addr.delete(); log_wd.delete(); log_we.delete();
    stat_q.delete();
    stat_idx = 0; n_rd = 0; stab_err = 0; max_wait = 0; done_cnt = 0; err_at = -1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (done_o === 1'b1) done_cnt++;

  initial begin : responder
    logic        rsp_pend;
    logic [31:0] pend_rd;
    logic        pend_err;
    int          wait_cnt;
    logic        hold_vld;
    logic [31:0] hold_addr, hold_wd;
    logic        hold_we;
    rsp_pend = 1'b0; wait_cnt = 0; hold_vld = 1'b0;
    pend_rd = '0; pend_err = 1'b0; hold_addr = '0; hold_wd = '0; hold_we = 1'b0;
    gnt_i = 1'b0; rvalid_i = 1'b0; err_i = 1'b0; rdata_i = '0;
    forever begin
      @(negedge clk);
      gnt_i    = 1'b0;
      rvalid_i = force_rv;
      err_i    = force_rv & force_err;
      rdata_i  = force_rv ? 32'h1 : 32'h0;
      if (rst_n !== 1'b1) begin
        rsp_pend = 1'b0; wait_cnt = 0; hold_vld = 1'b0;
      end else if (rsp_pend) begin
        rvalid_i = 1'b1; rdata_i = pend_rd; err_i = pend_err; rsp_pend = 1'b0;
      end else if (req_o === 1'b1) begin
        if (hold_vld && (addr_o !== hold_addr || wdata_o !== hold_wd ||
                         we_o !== hold_we || be_o !== 4'hF))
          stab_err++;
        if (wait_cnt >= gnt_delay) begin
          gnt_i    = 1'b1;
          hold_vld = 1'b0;
          wait_cnt = 0;
          pend_err = (log_addr.size() == err_at);
          pend_rd  = '0;
          if (!we_o) begin
            pend_rd = (stat_idx < stat_q.size()) ? 32'(stat_q[stat_idx]) : 32'h0;
            stat_idx++;
            n_rd++;
          end
          log_addr.push_back(addr_o); log_wd.push_back(wdata_o); log_we.push_back(we_o);
          rsp_pend = 1'b1;
        end else begin
          wait_cnt++;
          if (wait_cnt > max_wait) max_wait = wait_cnt;
          hold_vld = 1'b1; hold_addr = addr_o; hold_wd = wdata_o; hold_we = we_o;
        end
      end
    end
  end

  // Issues a job from IDLE and waits (bounded) for done_o; lat counts negedges.
  task automatic run_job(input logic [7:0] op, input logic [7:0] nb, output int lat);
    cmd_op = op; cmd_nb = nb; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (done_o !== 1'b1 && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 300) begin
      checks++; errors++;
      $error("FAIL job_timeout observed=no_done expected=done");
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin : stim
    int lat;
    int k;
    int req_seen;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_nb = '0;
    repeat (3) @(negedge clk);
    chk("rst_req", req_o, 0);
    chk("rst_be", be_o, 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_done", done_o, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ready", cmd_ready, 1);
    chk("idle_no_req", req_o, 0);

    // Basic job, grant after one wait cycle, STATUS done on first poll
    clear_log(); gnt_delay = 1; stat_q.push_back(1);
    run_job(8'd2, 8'd16, lat);
    chk("a_ntx", log_addr.size(), 4);
    chk("a_addr0", log_addr[0], BASE + 32'h0);
    chk("a_wd0", log_wd[0], 32'd2);
    chk("a_addr1", log_addr[1], BASE + 32'h4);
    chk("a_wd1", log_wd[1], 32'd16);
    chk("a_addr2", log_addr[2], BASE + 32'h8);
    chk("a_wd2", log_wd[2], 32'd1);
    chk("a_we2", log_we[2], 1);
    chk("a_addr3", log_addr[3], BASE + 32'hC);
    chk("a_we3", log_we[3], 0);
    chk("a_nrd", n_rd, 1);
    chk("a_done", done_cnt, 1);
    chk("a_err", core_err, 0);
    chk("a_bus", bus_err, 0);
    chk("a_to", timeout, 0);
    chk("a_ready", cmd_ready, 1);

    // Zero-wait responder: 4 x 2 cycles then REPORT
    clear_log(); gnt_delay = 0; stat_q.push_back(1);
    run_job(8'h5A, 8'hA5, lat);
    chk("lat_min", lat, 9);
    chk("lat_wd0", log_wd[0], 32'h5A);
    chk("lat_wd1", log_wd[1], 32'hA5);

    // STATUS busy three times, then done with error code 3
    clear_log(); gnt_delay = 0;
    stat_q.push_back(0); stat_q.push_back(0); stat_q.push_back(0); stat_q.push_back(7);
    run_job(8'd3, 8'd4, lat);
    chk("b_nrd", n_rd, 4);
    chk("b_ntx", log_addr.size(), 7);
    chk("b_addr6", log_addr[6], BASE + 32'hC);
    chk("b_done", done_cnt, 1);
    chk("b_err", core_err, 3);
    chk("b_to", timeout, 0);

    // Bus error on band-count write: no START, error reported
    clear_log(); gnt_delay = 0; err_at = 1;
    run_job(8'd1, 8'd2, lat);
    chk("c_ntx", log_addr.size(), 2);
    chk("c_bus", bus_err, 1);
    chk("c_done", done_cnt, 1);
    chk("c_err_clr", core_err, 0);
    chk("c_to", timeout, 0);

    // STATUS never ready: timeout after POLL_MAX reads
    clear_log(); gnt_delay = 0;
    run_job(8'd4, 8'd8, lat);
    chk("d_nrd", n_rd, 4);
    chk("d_to", timeout, 1);
    chk("d_done", done_cnt, 1);
    chk("d_bus_clr", bus_err, 0);

    // Spurious rvalid (with err) while idle must be ignored
    done_cnt = 0; force_rv = 1'b1; force_err = 1'b1;
    repeat (3) @(negedge clk);
    force_rv = 1'b0; force_err = 1'b0;
    repeat (2) @(negedge clk);
    chk("sp_bus", bus_err, 0);
    chk("sp_to_hold", timeout, 1);
    chk("sp_req", req_o, 0);
    chk("sp_done", done_cnt, 0);
    chk("sp_ready", cmd_ready, 1);

    // Grant withheld five cycles per transaction: request held stable
    clear_log(); gnt_delay = 5; stat_q.push_back(1);
    run_job(8'd9, 8'd10, lat);
    chk("g_wait", max_wait, 5);
    chk("g_stable", stab_err, 0);
    chk("g_ntx", log_addr.size(), 4);
    chk("g_done", done_cnt, 1);
    chk("g_to_clr", timeout, 0);

    // Reset asserted mid-poll
    clear_log(); gnt_delay = 0;
    cmd_op = 8'd7; cmd_nb = 8'd7; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    k = 0;
    while (n_rd < 2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("m_reach", (n_rd >= 2), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("m_req", req_o, 0);
    chk("m_addr", addr_o, 0);
    chk("m_we", we_o, 0);
    chk("m_be", be_o, 0);
    chk("m_done", done_o, 0);
    chk("m_ready", cmd_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    req_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (req_o === 1'b1) req_seen++;
    end
    chk("m_no_req", req_seen, 0);
    clear_log(); gnt_delay = 0; stat_q.push_back(32'h5);
    run_job(8'd6, 8'd12, lat);
    chk("m2_ntx", log_addr.size(), 4);
    chk("m2_wd1", log_wd[1], 32'd12);
    chk("m2_err", core_err, 2);
    chk("m2_done", done_cnt, 1);
    chk("m2_lat", lat, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hsi_core_cfg_sequencer.md
HSI_CORE_CFG_SEQUENCER -- requirements
Module: hsi_core_cfg_sequencer

Interface
REQ-001 Parameter OP_CODE_WIDTH, default 8, op code width.
REQ-002 Parameter NUM_BANDS_WIDTH, default 8, band count width.
REQ-003 Parameter ERR_WIDTH, default 8, core error code width; SHALL be <= 8.
REQ-004 Parameter BASE_ADDR, default 32'h0, base address of the vector core register block.
REQ-005 Parameter POLL_MAX, default 1024, maximum STATUS reads before timeout; SHALL be >= 1.
REQ-006 clk_i  input  1  single system clock; all logic on its rising edge.
REQ-007 rst_ni  input  1  asynchronous active-low reset.
REQ-008 cmd_valid_i  input  1  job request.
REQ-009 cmd_ready_o  output  1  job accepted when cmd_valid_i&&cmd_ready_o.
REQ-010 cmd_op_code_i  input  OP_CODE_WIDTH  op code for the job.
REQ-011 cmd_num_bands_i  input  NUM_BANDS_WIDTH  band count for the job.
REQ-012 done_o  output  1  one-cycle job-complete pulse.
REQ-013 core_err_code_o  output  ERR_WIDTH  error code read from STATUS[8:1].
REQ-014 bus_err_o  output  1  job aborted by bus error.
REQ-015 timeout_o  output  1  job aborted after POLL_MAX polls.
REQ-016 OBI initiator: req_o, we_o, be_o[3:0], addr_o[31:0], wdata_o[31:0] outputs; gnt_i, rvalid_i, rdata_i[31:0], err_i inputs.

Function
REQ-017 States: IDLE, REQ, RSP, REPORT; step register STEP in {WR_OP, WR_NB, WR_START, RD_STAT}.
REQ-018 IDLE: cmd_ready_o=1; on handshake latch op code and band count, clear core_err_code_o/bus_err_o/timeout_o, clear poll counter, STEP=WR_OP, go REQ.
REQ-019 Step targets: WR_OP addr BASE_ADDR+0x00, wdata zero-extended op code; WR_NB +0x04, zero-extended band count; WR_START +0x08, wdata 32'h1; RD_STAT +0x0C, we_o=0, wdata_o=0.
REQ-020 REQ: req_o=1, be_o=4'hF; addr_o/we_o/wdata_o SHALL be stable while req_o=1 and gnt_i=0; on gnt_i go RSP next cycle and drop req_o.
REQ-021 At most one outstanding transaction; rvalid_i SHALL be sampled only in RSP; rvalid_i outside RSP ignored.
REQ-022 RSP with rvalid_i&&err_i: set bus_err_o, go REPORT.
REQ-023 RSP with rvalid_i&&!err_i: WR_OP->WR_NB, WR_NB->WR_START, WR_START->RD_STAT, each back to REQ.
REQ-024 RD_STAT response: increment poll counter; if rdata_i[0]=1 capture rdata_i[ERR_WIDTH:1] into core_err_code_o, go REPORT; else if counter==POLL_MAX set timeout_o, go REPORT; else re-issue RD_STAT in REQ.
REQ-025 REPORT: done_o=1 for exactly one cycle, go IDLE; result outputs hold until next job accepted.
REQ-026 Minimum job latency with zero-wait-state responder: 4 transactions x 2 cycles + REPORT.
REQ-027 cmd_ready_o=0 in all states except IDLE; cmd_valid_i outside IDLE has no effect.
REQ-028 Poll counter width SHALL be $clog2(POLL_MAX+1); no wrap-around before timeout.

Reset
REQ-029 Reset SHALL act immediately, including mid-transaction: state IDLE, req_o=0, we_o=0, be_o=0, addr_o=0, wdata_o=0, done_o=0, bus_err_o=0, timeout_o=0, core_err_code_o=0, poll counter 0.
REQ-030 After reset deassertion no OBI request SHALL be issued until a new job is accepted.

Verification
REQ-031 Job op=2, bands=16, responder gnt after 1 cycle, STATUS=0x1 on first poll -> writes 0x00=2, 0x04=16, 0x08=1, one read 0x0C, done_o pulse, core_err_code_o=0, bus_err_o=0.
REQ-032 STATUS returns 0x0 three times then 0x7 -> four reads of 0x0C, done_o once, core_err_code_o=3.
REQ-033 err_i=1 on WR_NB response -> no START write, done_o pulse, bus_err_o=1.
REQ-034 POLL_MAX=4, STATUS always 0 -> exactly 4 reads, timeout_o=1, done_o pulse.
REQ-035 gnt_i withheld 5 cycles -> req_o/addr_o/wdata_o constant all 5 cycles; spurious rvalid_i in IDLE -> ignored.
REQ-036 rst_ni low during RD_STAT poll -> all outputs at reset values same cycle; fresh job afterwards completes normally.
